// File: rtl/mouse_pkg.sv
// Shared types and default constants for the mouse cursor tracker.
package mouse_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_CALC    = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_INIT_X   = 320;
    localparam int DEF_INIT_Y   = 240;
    localparam int INC_BITS     = 9;

endpackage

// File: rtl/cursor_axis_clamp.sv
// One cursor axis: scales a signed PS/2 increment, adds or subtracts it and clamps
// to 0..MAX_VAL. Optional doubling of large increments under MOUSE_CURSOR_ACCEL_EN.
module cursor_axis_clamp
    import mouse_pkg::*;
#(
    parameter int AXIS_BITS    = 10,
    parameter int MAX_VAL      = 639,
    parameter int GAIN_SHIFT   = 0,
    parameter int ACCEL_THRESH = 16
) (
    input  logic [AXIS_BITS-1:0] pos,
    input  logic [INC_BITS-1:0]  inc,
    input  logic                 sub,
    output logic [AXIS_BITS-1:0] next_pos
);

    localparam int W = AXIS_BITS + 6;
    localparam logic signed [W-1:0] MAX_S = W'(MAX_VAL);
`ifdef MOUSE_CURSOR_ACCEL_EN
    localparam logic signed [W-1:0] ACCEL_S = W'(ACCEL_THRESH);
`endif

    logic signed [W-1:0] inc_ext_s;
    logic signed [W-1:0] scaled_s;
    logic signed [W-1:0] delta_s;
    logic signed [W-1:0] pos_ext_s;
    logic signed [W-1:0] sum_s;
`ifdef MOUSE_CURSOR_ACCEL_EN
    logic signed [W-1:0] mag_s;
`endif

    // Scale, optionally accelerate, apply and clamp the increment
    always_comb begin
        inc_ext_s = {{(W-INC_BITS){inc[INC_BITS-1]}}, inc};
        scaled_s  = inc_ext_s <<< GAIN_SHIFT;
`ifdef MOUSE_CURSOR_ACCEL_EN
        // magnitude is taken on the raw increment, the doubling on the scaled one
        mag_s   = inc_ext_s[W-1] ? -inc_ext_s : inc_ext_s;
        delta_s = (mag_s > ACCEL_S) ? (scaled_s <<< 1) : scaled_s;
`else
        delta_s = scaled_s;
`endif
        pos_ext_s = {{(W-AXIS_BITS){1'b0}}, pos};
        if (sub) begin
            sum_s = pos_ext_s - delta_s;
        end else begin
            sum_s = pos_ext_s + delta_s;
        end
        if (sum_s[W-1]) begin
            next_pos = '0;
        end else if (sum_s > MAX_S) begin
            next_pos = MAX_S[AXIS_BITS-1:0];
        end else begin
            next_pos = sum_s[AXIS_BITS-1:0];
        end
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Integrates PS/2 mouse packets into a clamped absolute cursor with button edges.
// Optional acceleration is enabled by defining MOUSE_CURSOR_ACCEL_EN.
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int X_BITS       = 10,
    parameter int Y_BITS       = 10,
    parameter int INIT_X       = DEF_INIT_X,
    parameter int INIT_Y       = DEF_INIT_Y,
    parameter int GAIN_SHIFT   = 0,
    parameter int ACCEL_THRESH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INC_BITS-1:0] x_increment,
    input  logic [INC_BITS-1:0] y_increment,
    input  logic                left_button,
    input  logic                right_button,
    input  logic                data_ready,
    output logic                read,
    input  logic                recenter,
    output logic [X_BITS-1:0]   cursor_x,
    output logic [Y_BITS-1:0]   cursor_y,
    output logic                pos_valid,
    output logic                btn_left,
    output logic                btn_right,
    output logic                left_press,
    output logic                left_release,
    output logic                right_press
);

    state_t state_r;
    state_t state_nxt_s;

    logic [INC_BITS-1:0] hold_x_r;
    logic [INC_BITS-1:0] hold_y_r;
    logic                hold_left_r;
    logic                hold_right_r;
    logic                rc_pend_r;

    logic                accept_s;
    logic                publish_s;
    logic                recenter_apply_s;
    logic                recenter_req_s;

    logic [X_BITS-1:0]   cursor_x_r;
    logic [Y_BITS-1:0]   cursor_y_r;
    logic [X_BITS-1:0]   nx_s;
    logic [Y_BITS-1:0]   ny_s;
    logic                read_r;
    logic                pos_valid_r;
    logic                btn_left_r;
    logic                btn_right_r;
    logic                left_press_r;
    logic                left_release_r;
    logic                right_press_r;

    cursor_axis_clamp #(
        .AXIS_BITS   (X_BITS),
        .MAX_VAL     (SCREEN_W - 1),
        .GAIN_SHIFT  (GAIN_SHIFT),
        .ACCEL_THRESH(ACCEL_THRESH)
    ) u_clamp_x (
        .pos     (cursor_x_r),
        .inc     (hold_x_r),
        .sub     (1'b0),
        .next_pos(nx_s)
    );

    // Screen rows grow downward while PS/2 Y grows upward, hence subtract
    cursor_axis_clamp #(
        .AXIS_BITS   (Y_BITS),
        .MAX_VAL     (SCREEN_H - 1),
        .GAIN_SHIFT  (GAIN_SHIFT),
        .ACCEL_THRESH(ACCEL_THRESH)
    ) u_clamp_y (
        .pos     (cursor_y_r),
        .inc     (hold_y_r),
        .sub     (1'b1),
        .next_pos(ny_s)
    );

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt_s      = state_r;
        accept_s         = 1'b0;
        publish_s        = 1'b0;
        recenter_apply_s = 1'b0;
        recenter_req_s   = recenter | rc_pend_r;
        case (state_r)
            S_IDLE: begin
                if (recenter_req_s) begin
                    recenter_apply_s = 1'b1;
                end else if (data_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = S_ACK;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ACK: begin
                state_nxt_s = S_CALC;
            end
            S_CALC: begin
                publish_s   = 1'b1;
                state_nxt_s = S_PUBLISH;
            end
            S_PUBLISH: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_x_r     <= '0;
            hold_y_r     <= '0;
            hold_left_r  <= 1'b0;
            hold_right_r <= 1'b0;
        end else if (accept_s) begin
            hold_x_r     <= x_increment;
            hold_y_r     <= y_increment;
            hold_left_r  <= left_button;
            hold_right_r <= right_button;
        end else begin
            hold_x_r     <= hold_x_r;
            hold_y_r     <= hold_y_r;
            hold_left_r  <= hold_left_r;
            hold_right_r <= hold_right_r;
        end
    end

    // Recenter requested while busy waits here until the FSM is idle again
    always_ff @(posedge clk) begin
        if (reset) begin
            rc_pend_r <= 1'b0;
        end else if (recenter_apply_s) begin
            rc_pend_r <= 1'b0;
        end else if (recenter && (state_r != S_IDLE)) begin
            rc_pend_r <= 1'b1;
        end else begin
            rc_pend_r <= rc_pend_r;
        end
    end

    // Registered outputs: handshake, position, buttons and edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            read_r         <= 1'b0;
            pos_valid_r    <= 1'b0;
            cursor_x_r     <= X_BITS'(INIT_X);
            cursor_y_r     <= Y_BITS'(INIT_Y);
            btn_left_r     <= 1'b0;
            btn_right_r    <= 1'b0;
            left_press_r   <= 1'b0;
            left_release_r <= 1'b0;
            right_press_r  <= 1'b0;
        end else begin
            read_r         <= accept_s;
            pos_valid_r    <= publish_s | recenter_apply_s;
            left_press_r   <= publish_s & hold_left_r & ~btn_left_r;
            left_release_r <= publish_s & ~hold_left_r & btn_left_r;
            right_press_r  <= publish_s & hold_right_r & ~btn_right_r;
            if (recenter_apply_s) begin
                cursor_x_r <= X_BITS'(INIT_X);
                cursor_y_r <= Y_BITS'(INIT_Y);
            end else if (publish_s) begin
                cursor_x_r <= nx_s;
                cursor_y_r <= ny_s;
            end else begin
                cursor_x_r <= cursor_x_r;
                cursor_y_r <= cursor_y_r;
            end
            if (publish_s) begin
                btn_left_r  <= hold_left_r;
                btn_right_r <= hold_right_r;
            end else begin
                btn_left_r  <= btn_left_r;
                btn_right_r <= btn_right_r;
            end
        end
    end

    assign read         = read_r;
    assign pos_valid    = pos_valid_r;
    assign cursor_x     = cursor_x_r;
    assign cursor_y     = cursor_y_r;
    assign btn_left     = btn_left_r;
    assign btn_right    = btn_right_r;
    assign left_press   = left_press_r;
    assign left_release = left_release_r;
    assign right_press  = right_press_r;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed self-checking bench for mouse_cursor_tracker (default 640x480 build).
module tb_mouse_cursor_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] x_increment;
    logic [8:0] y_increment;
    logic       left_button;
    logic       right_button;
    logic       data_ready;
    logic       read;
    logic       recenter;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic       pos_valid;
    logic       btn_left;
    logic       btn_right;
    logic       left_press;
    logic       left_release;
    logic       right_press;

    int total = 0;
    int bad   = 0;
    int rd_lat;
    int pv_lat;
    int extra_rd;
    logic [31:0] cap_x;
    logic [31:0] cap_y;
    logic cap_pv, cap_bl, cap_br, cap_lp, cap_lr, cap_rp;
    logic post_pv, post_lp;

    always #5 clk = ~clk;

    mouse_cursor_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .x_increment (x_increment),
        .y_increment (y_increment),
        .left_button (left_button),
        .right_button(right_button),
        .data_ready  (data_ready),
        .read        (read),
        .recenter    (recenter),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .pos_valid   (pos_valid),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .left_press  (left_press),
        .left_release(left_release),
        .right_press (right_press)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one packet, wait (bounded) for read and pos_valid, capture outputs
    task automatic send(input logic [8:0] xi, input logic [8:0] yi, input logic l, input logic r);
        x_increment  = xi;
        y_increment  = yi;
        left_button  = l;
        right_button = r;
        data_ready   = 1'b1;
        rd_lat = 0;
        do begin
            step;
            rd_lat++;
        end while (read !== 1'b1 && rd_lat < 8);
        data_ready = 1'b0;
        pv_lat   = rd_lat;
        extra_rd = 0;
        do begin
            step;
            pv_lat++;
            if (read === 1'b1) extra_rd++;
        end while (pos_valid !== 1'b1 && pv_lat < 16);
        cap_pv = pos_valid;
        cap_x  = 32'(cursor_x);
        cap_y  = 32'(cursor_y);
        cap_bl = btn_left;
        cap_br = btn_right;
        cap_lp = left_press;
        cap_lr = left_release;
        cap_rp = right_press;
        step;
        post_pv = pos_valid;
        post_lp = left_press;
    endtask

    task automatic expect_pos(input string tag, input int ex, input int ey);
        chk({tag, "_pv"}, 32'(cap_pv), 32'd1);
        chk({tag, "_x"}, cap_x, 32'(ex));
        chk({tag, "_y"}, cap_y, 32'(ey));
    endtask

    initial begin
        reset = 1'b1;
        x_increment = 9'd0;
        y_increment = 9'd0;
        left_button = 1'b0;
        right_button = 1'b0;
        data_ready = 1'b0;
        recenter = 1'b0;
        step;
        step;
        chk("rst_x", 32'(cursor_x), 32'd320);
        chk("rst_y", 32'(cursor_y), 32'd240);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_pv", 32'(pos_valid), 32'd0);
        chk("rst_btns", 32'({btn_left, btn_right, left_press, left_release, right_press}), 32'd0);
        reset = 1'b0;
        step;

        // basic move and latency
        send(9'h005, 9'h1FF, 1'b0, 1'b0);
        chk("t1_rd_lat", 32'(rd_lat), 32'd1);
        chk("t1_pv_lat", 32'(pv_lat), 32'd3);
        chk("t1_read_once", 32'(extra_rd), 32'd0);
        expect_pos("t1", 325, 241);
        chk("t1_pv_pulse", 32'(post_pv), 32'd0);

        // drive to the low corner, then clamp low
        send(9'h100, 9'h0FF, 1'b0, 1'b0);
        expect_pos("t2a", 69, 0);
        send(9'h100, 9'h0FF, 1'b0, 1'b0);
        expect_pos("t2b", 0, 0);
        send(9'h1F6, 9'h014, 1'b0, 1'b0);
        expect_pos("t2c", 0, 0);

        // walk to (630,470), then clamp high
        send(9'h0FF, 9'h101, 1'b0, 1'b0);
        expect_pos("t3a", 255, 255);
        send(9'h0FF, 9'h129, 1'b0, 1'b0);
        expect_pos("t3b", 510, 470);
        send(9'h078, 9'h000, 1'b0, 1'b0);
        expect_pos("t3c", 630, 470);
        send(9'h07F, 9'h180, 1'b0, 1'b0);
        expect_pos("t3d", 639, 479);
        send(9'h1FF, 9'h001, 1'b0, 1'b0);
        expect_pos("t3e", 638, 478);

        // button edges with zero motion
        send(9'h000, 9'h000, 1'b1, 1'b0);
        expect_pos("t4a", 638, 478);
        chk("t4a_lp", 32'(cap_lp), 32'd1);
        chk("t4a_lr", 32'(cap_lr), 32'd0);
        chk("t4a_bl", 32'(cap_bl), 32'd1);
        chk("t4a_lp_pulse", 32'(post_lp), 32'd0);
        send(9'h000, 9'h000, 1'b0, 1'b0);
        chk("t4b_lp", 32'(cap_lp), 32'd0);
        chk("t4b_lr", 32'(cap_lr), 32'd1);
        chk("t4b_bl", 32'(cap_bl), 32'd0);
        send(9'h000, 9'h000, 1'b0, 1'b1);
        chk("t4c_rp", 32'(cap_rp), 32'd1);
        chk("t4c_br", 32'(cap_br), 32'd1);
        send(9'h000, 9'h000, 1'b0, 1'b0);
        chk("t4d_rp", 32'(cap_rp), 32'd0);
        chk("t4d_br", 32'(cap_br), 32'd0);

        // recenter collides with data_ready in idle
        x_increment = 9'h005;
        y_increment = 9'h000;
        left_button = 1'b1;
        data_ready = 1'b1;
        recenter = 1'b1;
        step;
        recenter = 1'b0;
        chk("t5_rc_pv", 32'(pos_valid), 32'd1);
        chk("t5_rc_x", 32'(cursor_x), 32'd320);
        chk("t5_rc_y", 32'(cursor_y), 32'd240);
        chk("t5_rc_read", 32'(read), 32'd0);
        chk("t5_rc_noedge", 32'({left_press, btn_left}), 32'd0);
        step;
        chk("t5_read", 32'(read), 32'd1);
        data_ready = 1'b0;
        step;
        step;
        chk("t5_pv", 32'(pos_valid), 32'd1);
        chk("t5_x", 32'(cursor_x), 32'd325);
        chk("t5_lp", 32'(left_press), 32'd1);
        step;

        // recenter arriving while a packet is in flight
        x_increment = 9'h003;
        data_ready = 1'b1;
        step;
        chk("t6_read", 32'(read), 32'd1);
        data_ready = 1'b0;
        recenter = 1'b1;
        step;
        recenter = 1'b0;
        step;
        chk("t6_pv", 32'(pos_valid), 32'd1);
        chk("t6_x", 32'(cursor_x), 32'd328);
        chk("t6_lp", 32'(left_press), 32'd0);
        step;
        chk("t6_gap", 32'(pos_valid), 32'd0);
        step;
        chk("t6_rc_pv", 32'(pos_valid), 32'd1);
        chk("t6_rc_x", 32'(cursor_x), 32'd320);
        chk("t6_rc_bl", 32'(btn_left), 32'd1);
        step;

        // reset mid-packet; upstream keeps data_ready high
        x_increment = 9'h007;
        left_button = 1'b0;
        data_ready = 1'b1;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("t7_rst_read", 32'(read), 32'd0);
        chk("t7_rst_bl", 32'(btn_left), 32'd0);
        step;
        chk("t7_reread", 32'(read), 32'd1);
        data_ready = 1'b0;
        step;
        step;
        chk("t7_pv", 32'(pos_valid), 32'd1);
        chk("t7_x", 32'(cursor_x), 32'd327);
        step;

`ifdef MOUSE_CURSOR_ACCEL_EN
        recenter = 1'b1;
        step;
        recenter = 1'b0;
        step;
        send(9'h014, 9'h000, 1'b0, 1'b0);
        expect_pos("acc_a", 360, 240);
        send(9'h010, 9'h000, 1'b0, 1'b0);
        expect_pos("acc_b", 376, 240);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
